// File: rtl/mt6835_angle_reader.sv
// mt6835_angle_reader: MT6835 burst reader with a built-in SPI mode-3 engine.
// Reads ANGLE/STATUS/CRC, checks CRC-8 and keeps the last good angle.
module mt6835_angle_reader #(
    parameter int CLKS_PER_HALF_BIT = 8,
    parameter int CS_SETUP_CYCLES   = 2,
    parameter int CS_HOLD_CYCLES    = 2,
    parameter int GAP_CYCLES        = 16,
    parameter int OUT_BITS          = 12,
    parameter bit CONTINUOUS        = 1'b1,
    parameter int ERR_CNT_BITS      = 8
) (
    input  logic                    i_clk,
    input  logic                    rstn,
    input  logic                    i_en,
    input  logic                    i_trig,
    output logic                    spi_clk,
    output logic                    spi_cs,
    output logic                    spi_mosi,
    input  logic                    spi_miso,
    output logic [20:0]             o_angle_21,
    output logic [OUT_BITS-1:0]     o_angle,
    output logic [2:0]              o_status,
    output logic                    o_valid,
    output logic                    o_crc_err,
    output logic [ERR_CNT_BITS-1:0] o_err_cnt,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, CHECK, GAP
    } state_t;

    localparam int H2   = 2 * CLKS_PER_HALF_BIT;
    localparam int M1   = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                          CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int M2   = (GAP_CYCLES > H2) ? GAP_CYCLES : H2;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(H2 - 1);
    localparam logic [15:0]   CMD        = 16'hA003;
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [5:0]      bit_cnt;
    logic [15:0]     tx;
    logic [31:0]     rx;
    logic            start_req;
    logic            setup_done;
    logic            half_end;
    logic            bit_end;
    logic            last_bit;
    logic            hold_done;
    logic            gap_done;
    logic            cs_nx;
    logic            sclk_fall;
    logic            sclk_rise;
    logic            do_check;
    logic            crc_ok;

    // MSB-first CRC-8, poly 0x07, zero init, over D0..D2
    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign start_req  = i_en && (CONTINUOUS || i_trig);
    assign setup_done = (cnt == SETUP_LAST);
    assign half_end   = (cnt == HALF_LAST);
    assign bit_end    = (cnt == BIT_LAST);
    assign last_bit   = (bit_cnt == 6'd47);
    assign hold_done  = (cnt == HOLD_LAST);
    assign gap_done   = (cnt == GAP_LAST);
    assign crc_ok     = (crc8(rx[31:8]) == rx[7:0]);
    assign o_angle    = o_angle_21[20 -: OUT_BITS];

    // State register
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_req) state_nx = SETUP;
            SETUP:   if (setup_done) state_nx = SHIFT;
            SHIFT:   if (bit_end && last_bit) state_nx = HOLD;
            HOLD:    if (hold_done) state_nx = CHECK;
            CHECK:   state_nx = GAP;
            GAP:     if (gap_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM-decoded controls; CS follows the next state so it is a clean flop
    always_comb begin
        o_busy    = (state != IDLE);
        cs_nx     = !(state_nx inside {SETUP, SHIFT, HOLD});
        sclk_fall = (state == SETUP && setup_done) ||
                    (state == SHIFT && bit_end && !last_bit);
        sclk_rise = (state == SHIFT) && half_end;
        do_check  = (state == CHECK);
    end

    // Per-state cycle counter; also times each SCLK bit in SHIFT
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (state_nx != state || (state == SHIFT && bit_end))
            cnt <= '0;
        else if (state != IDLE)
            cnt <= cnt + 1'b1;
    end

    // Command shifter, bit counter and receive shifter
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
        end else begin
            if (state == IDLE && state_nx == SETUP) begin
                bit_cnt <= '0;
                tx      <= CMD;
            end else if (sclk_fall) begin
                tx <= {tx[14:0], 1'b0};
            end
            if (state == SHIFT && bit_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (sclk_rise)
                rx <= {rx[30:0], spi_miso};
        end
    end

    // SPI pins: MOSI changes on SCLK fall, SCLK idles high
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            spi_cs <= cs_nx;
            if (sclk_fall) begin
                spi_clk  <= 1'b0;
                spi_mosi <= tx[15];
            end else if (sclk_rise) begin
                spi_clk <= 1'b1;
            end
        end
    end

    // Publish on good CRC, otherwise pulse error and count it
    always_ff @(posedge i_clk or negedge rstn) begin
        if (!rstn) begin
            o_angle_21 <= '0;
            o_status   <= '0;
            o_valid    <= 1'b0;
            o_crc_err  <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            o_valid   <= 1'b0;
            o_crc_err <= 1'b0;
            if (do_check) begin
                if (crc_ok) begin
                    o_angle_21 <= rx[31:11];
                    o_status   <= rx[10:8];
                    o_valid    <= 1'b1;
                end else begin
                    o_crc_err <= 1'b1;
                    if (o_err_cnt != ERR_MAX)
                        o_err_cnt <= o_err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mt6835_angle_reader.sv
// tb_mt6835_angle_reader: sensor models plus scoreboard for two reader
// instances, one free-running and one triggered.
`timescale 1ns/1ps
module tb_mt6835_angle_reader;

    localparam int H   = 4;
    localparam int SU  = 3;
    localparam int HD  = 2;
    localparam int GP  = 16;
    localparam int OB  = 12;

    typedef struct {
        logic        ok;
        logic [20:0] ang;
        logic [2:0]  st;
        logic [7:0]  ec;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic en_c = 1'b0, trig_c = 1'b0, miso_c = 1'b0;
    logic sclk_c, cs_c, mosi_c, val_c, cerr_c, busy_c;
    logic [20:0] ang21_c;
    logic [OB-1:0] ang_c;
    logic [2:0] st_c;
    logic [1:0] ec_c;

    logic en_t = 1'b0, trig_t = 1'b0, miso_t = 1'b0;
    logic sclk_t, cs_t, mosi_t, val_t, cerr_t, busy_t;
    logic [20:0] ang21_t;
    logic [OB-1:0] ang_t;
    logic [2:0] st_t;
    logic [7:0] ec_t;

    mt6835_angle_reader #(
        .CLKS_PER_HALF_BIT(H), .CS_SETUP_CYCLES(SU), .CS_HOLD_CYCLES(HD),
        .GAP_CYCLES(GP), .OUT_BITS(OB), .CONTINUOUS(1'b1), .ERR_CNT_BITS(2)
    ) u_cont (
        .i_clk(clk), .rstn(rstn), .i_en(en_c), .i_trig(trig_c),
        .spi_clk(sclk_c), .spi_cs(cs_c), .spi_mosi(mosi_c), .spi_miso(miso_c),
        .o_angle_21(ang21_c), .o_angle(ang_c), .o_status(st_c),
        .o_valid(val_c), .o_crc_err(cerr_c), .o_err_cnt(ec_c), .o_busy(busy_c)
    );

    mt6835_angle_reader #(
        .CLKS_PER_HALF_BIT(H), .CS_SETUP_CYCLES(SU), .CS_HOLD_CYCLES(HD),
        .GAP_CYCLES(GP), .OUT_BITS(OB), .CONTINUOUS(1'b0), .ERR_CNT_BITS(8)
    ) u_trig (
        .i_clk(clk), .rstn(rstn), .i_en(en_t), .i_trig(trig_t),
        .spi_clk(sclk_t), .spi_cs(cs_t), .spi_mosi(mosi_t), .spi_miso(miso_t),
        .o_angle_21(ang21_t), .o_angle(ang_t), .o_status(st_t),
        .o_valid(val_t), .o_crc_err(cerr_t), .o_err_cnt(ec_t), .o_busy(busy_t)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference CRC, byte-at-a-time
    function automatic logic [7:0] crc_ref(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
        logic [7:0] c;
        logic [7:0] by [3];
        by[0] = b0; by[1] = b1; by[2] = b2;
        c = 8'h00;
        for (int k = 0; k < 3; k++) begin
            c = c ^ by[k];
            for (int j = 0; j < 8; j++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [47:0] fq_c[$];
    logic [47:0] fq_t[$];
    exp_t sb_c[$];
    exp_t sb_t[$];
    logic [20:0] m_ang_c = '0, m_ang_t = '0;
    logic [2:0]  m_st_c = '0, m_st_t = '0;
    int          m_ec_c = 0, m_ec_t = 0;

    task automatic push_frame(input bit tdut, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3);
        exp_t e;
        logic ok;
        ok = (crc_ref(d0, d1, d2) == d3);
        e.ok = ok;
        if (!tdut) begin
            if (ok) begin
                m_ang_c = {d0, d1, d2[7:3]};
                m_st_c  = d2[2:0];
            end else if (m_ec_c < 3) begin
                m_ec_c++;
            end
            e.ang = m_ang_c; e.st = m_st_c; e.ec = 8'(m_ec_c);
            fq_c.push_back({16'h0, d0, d1, d2, d3});
            sb_c.push_back(e);
        end else begin
            if (ok) begin
                m_ang_t = {d0, d1, d2[7:3]};
                m_st_t  = d2[2:0];
            end else if (m_ec_t < 255) begin
                m_ec_t++;
            end
            e.ang = m_ang_t; e.st = m_st_t; e.ec = 8'(m_ec_t);
            fq_t.push_back({16'h0, d0, d1, d2, d3});
            sb_t.push_back(e);
        end
    endtask

    // Sensor models: shift frame out on SCLK fall, capture MOSI on rise
    logic [47:0] sh_c, sh_t, mcap_c = '0, last_mosi_c = '0;
    int csf_c = 0, csf_t = 0;
    always @(negedge cs_c) begin
        sh_c = (fq_c.size() != 0) ? fq_c.pop_front() : 48'h0;
        csf_c++;
    end
    always @(negedge sclk_c) if (!cs_c) begin
        miso_c = sh_c[47];
        sh_c = {sh_c[46:0], 1'b0};
    end
    always @(posedge sclk_c) if (!cs_c) mcap_c = {mcap_c[46:0], mosi_c};
    always @(posedge cs_c) last_mosi_c = mcap_c;
    always @(negedge cs_t) begin
        sh_t = (fq_t.size() != 0) ? fq_t.pop_front() : 48'h0;
        csf_t++;
    end
    always @(negedge sclk_t) if (!cs_t) begin
        miso_t = sh_t[47];
        sh_t = {sh_t[46:0], 1'b0};
    end

    // Timing monitor on the free-running instance
    int cyc = 0;
    always @(posedge clk) cyc++;
    logic pcs = 1'b1, pclk = 1'b1;
    int t_csf = 0, t_csr = -1, t_lf = 0, n_rise = 0, n_fall = 0;
    int setup_meas = 0, per_min = 1000000, per_max = 0;
    int low_len = 0, last_rise = 0, gap_min = 1000000;
    always @(negedge clk) begin
        if (pcs && !cs_c) begin
            t_csf = cyc; n_rise = 0; n_fall = 0;
            if (t_csr >= 0 && (cyc - t_csr) < gap_min) gap_min = cyc - t_csr;
        end
        if (!cs_c && pclk && !sclk_c) begin
            if (n_fall == 0) begin
                setup_meas = cyc - t_csf;
            end else begin
                if (cyc - t_lf < per_min) per_min = cyc - t_lf;
                if (cyc - t_lf > per_max) per_max = cyc - t_lf;
            end
            t_lf = cyc;
            n_fall++;
        end
        if (!cs_c && !pclk && sclk_c) n_rise++;
        if (!pcs && cs_c) begin
            t_csr = cyc; low_len = cyc - t_csf; last_rise = n_rise;
        end
        pcs = cs_c; pclk = sclk_c;
    end

    // Scoreboard: pop and compare on every result pulse
    exp_t e_c, e_t;
    always @(negedge clk) begin
        if (val_c || cerr_c) begin
            if (sb_c.size() == 0) begin
                chk("c_unexpected_pulse", 32'({val_c, cerr_c}), 32'h0);
            end else begin
                e_c = sb_c.pop_front();
                chk("c_kind", 32'({val_c, cerr_c}), e_c.ok ? 32'h2 : 32'h1);
                chk("c_ang21", 32'(ang21_c), 32'(e_c.ang));
                chk("c_ang", 32'(ang_c), 32'(e_c.ang[20 -: OB]));
                chk("c_status", 32'(st_c), 32'(e_c.st));
                chk("c_errcnt", 32'(ec_c), 32'(e_c.ec));
            end
        end
        if (val_t || cerr_t) begin
            if (sb_t.size() == 0) begin
                chk("t_unexpected_pulse", 32'({val_t, cerr_t}), 32'h0);
            end else begin
                e_t = sb_t.pop_front();
                chk("t_kind", 32'({val_t, cerr_t}), e_t.ok ? 32'h2 : 32'h1);
                chk("t_ang21", 32'(ang21_t), 32'(e_t.ang));
                chk("t_ang", 32'(ang_t), 32'(e_t.ang[20 -: OB]));
                chk("t_status", 32'(st_t), 32'(e_t.st));
                chk("t_errcnt", 32'(ec_t), 32'(e_t.ec));
            end
        end
    end

    task automatic wait_drain(input bit tdut, input int lim);
        int k;
        k = 0;
        while (k < lim && ((tdut ? sb_t.size() : sb_c.size()) != 0 ||
                           (tdut ? busy_t : busy_c))) begin
            @(negedge clk);
            k++;
        end
        chk(tdut ? "t_drain_timeout" : "c_drain_timeout", 32'(k < lim), 32'h1);
    endtask

    task automatic run_cont(input int n);
        int target, k;
        target = csf_c + n;
        k = 0;
        en_c = 1'b1;
        while (csf_c < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        en_c = 1'b0;
        chk("c_bursts_started", 32'(csf_c), 32'(target));
        wait_drain(1'b0, 2000);
    endtask

    initial begin
        int k, base;
        #2 rstn = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_cs", 32'(cs_c), 32'h1);
        chk("rst_sclk", 32'(sclk_c), 32'h1);
        chk("rst_mosi", 32'(mosi_c), 32'h0);
        chk("rst_ang21", 32'(ang21_c), 32'h0);
        chk("rst_pulses", 32'({val_c, cerr_c, busy_c}), 32'h0);
        rstn = 1'b1;
        en_t = 1'b1;

        // First burst: command word, angle 1, truncated angle 0
        push_frame(1'b0, 8'h00, 8'h00, 8'h08, 8'h38);
        run_cont(1);
        chk("mosi_cmd", 32'(last_mosi_c[47:32]), 32'hA003);
        chk("mosi_zero", last_mosi_c[31:0], 32'h0);
        chk("o_angle_small", 32'(ang_c), 32'h0);

        // Back-to-back free-running bursts
        push_frame(1'b0, 8'h00, 8'h00, 8'h0C, 8'h24);
        push_frame(1'b0, 8'h80, 8'h00, 8'h00, 8'h0B);
        run_cont(2);
        chk("o_angle_top", 32'(ang_c), 32'h800);

        // Bad CRC keeps angle, counter saturates at 3
        push_frame(1'b0, 8'h80, 8'h00, 8'h00, 8'h00);
        run_cont(1);
        chk("held_after_bad", 32'(ang_c), 32'h800);
        chk("errcnt_one", 32'(ec_c), 32'h1);
        for (int i = 0; i < 4; i++)
            push_frame(1'b0, 8'h12, 8'h34, 8'h56, 8'h00);
        run_cont(4);
        chk("errcnt_sat", 32'(ec_c), 32'h3);
        base = csf_c;
        repeat (100) @(negedge clk);
        chk("no_restart_en_low", 32'(csf_c), 32'(base));

        // SPI timing of the runs so far
        chk("cs_setup", 32'(setup_meas), 32'(SU));
        chk("sclk_per_min", 32'(per_min), 32'(2 * H));
        chk("sclk_per_max", 32'(per_max), 32'(2 * H));
        chk("sclk_rises", 32'(last_rise), 32'd48);
        chk("cs_low_len", 32'(low_len), 32'(SU + 96 * H + HD));
        chk("cs_gap_ok", 32'(gap_min >= GP), 32'h1);

        // Triggered instance: idle until a trigger, one burst per trigger
        chk("t_no_trig_idle", 32'(csf_t), 32'h0);
        push_frame(1'b1, 8'h80, 8'h00, 8'h00, 8'h0B);
        trig_t = 1'b1;
        @(negedge clk);
        trig_t = 1'b0;
        k = 0;
        while (!busy_t && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t_busy", 32'(busy_t), 32'h1);
        repeat (20) @(negedge clk);
        trig_t = 1'b1;
        @(negedge clk);
        trig_t = 1'b0;
        wait_drain(1'b1, 2000);
        repeat (200) @(negedge clk);
        chk("t_one_burst", 32'(csf_t), 32'h1);
        chk("t_busy_idle", 32'(busy_t), 32'h0);

        // Reset in the low phase of bit 20
        fq_c.push_back({16'h0, 8'h55, 8'h55, 8'h55, 8'h00});
        base = csf_c + 1;
        en_c = 1'b1;
        k = 0;
        while (!(csf_c == base && n_rise >= 20 && !sclk_c) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_bit20", 32'(k < 3000), 32'h1);
        rstn = 1'b0;
        #1;
        chk("arst_cs", 32'(cs_c), 32'h1);
        chk("arst_sclk", 32'(sclk_c), 32'h1);
        chk("arst_ang21", 32'(ang21_c), 32'h0);
        chk("arst_ang", 32'(ang_c), 32'h0);
        chk("arst_status_cnt", 32'({st_c, ec_c}), 32'h0);
        chk("arst_flags", 32'({val_c, cerr_c, busy_c}), 32'h0);
        chk("arst_t_ang21", 32'(ang21_t), 32'h0);
        m_ang_c = '0; m_st_c = '0; m_ec_c = 0;
        m_ang_t = '0; m_st_t = '0; m_ec_t = 0;
        en_c = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        push_frame(1'b0, 8'h00, 8'h00, 8'h08, 8'h38);
        run_cont(1);
        chk("post_rst_mosi", 32'(last_mosi_c[47:32]), 32'hA003);
        chk("post_rst_rises", 32'(last_rise), 32'd48);
        chk("post_rst_low_len", 32'(low_len), 32'(SU + 96 * H + HD));

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
